// File: rtl/bsg_manycore_eva_to_npa_pipe.sv
// bsg_manycore_eva_to_npa_pipe
//   Two-stage valid/ready EVA -> NPA translator for a manycore endpoint.
//   Stage 1 captures the EVA and the tile-group/DRAM configuration and decodes the
//   address class; stage 2 forms (x, y, epa) and holds it as the output register.
//   Also flags invalid or out-of-group addresses and counts invalid results consumed.
// Ports:
//   clk_i, reset_n_i              clock, asynchronous active-low reset
//   v_i, ready_o, eva_i           request handshake and 32-bit byte EVA
//   tgo_x_i, tgo_y_i              tile-group origin
//   tg_lg_dim_x_i, tg_lg_dim_y_i  log2 tile-group dimensions (0..4)
//   dram_enable_i                 striped DRAM mode
//   v_o, yumi_i                   result handshake
//   x_cord_o, y_cord_o, epa_o     translated NPA
//   invalid_o                     result is invalid (NPA forced to zero)
//   fault_cnt_o, clear_fault_i    saturating invalid-result counter and its clear
module bsg_manycore_eva_to_npa_pipe #(
  parameter int unsigned data_width_p                 = 32,
  parameter int unsigned addr_width_p                 = 28,
  parameter int unsigned x_cord_width_p               = 4,
  parameter int unsigned y_cord_width_p               = 4,
  parameter int unsigned num_tiles_x_p                = 16,
  parameter int unsigned num_tiles_y_p                = 8,
  parameter int unsigned vcache_block_size_in_words_p = 8,
  parameter int unsigned vcache_size_p                = 1024,
  parameter int unsigned dram_banks_p                 = 2 * num_tiles_x_p,
  parameter int unsigned dmem_start_p                 = 'h400,
  parameter int unsigned fault_cnt_width_p            = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [data_width_p-1:0]      eva_i,
  input  logic [x_cord_width_p-1:0]    tgo_x_i,
  input  logic [y_cord_width_p-1:0]    tgo_y_i,
  input  logic [2:0]                   tg_lg_dim_x_i,
  input  logic [2:0]                   tg_lg_dim_y_i,
  input  logic                         dram_enable_i,
  output logic                         v_o,
  input  logic                         yumi_i,
  output logic [x_cord_width_p-1:0]    x_cord_o,
  output logic [y_cord_width_p-1:0]    y_cord_o,
  output logic [addr_width_p-1:0]      epa_o,
  output logic                         invalid_o,
  output logic [fault_cnt_width_p-1:0] fault_cnt_o,
  input  logic                         clear_fault_i
);

  localparam int unsigned Vb = $clog2(vcache_block_size_in_words_p);
  localparam int unsigned Vs = $clog2(vcache_size_p);
  localparam int unsigned Nb = $clog2(dram_banks_p);
  localparam int unsigned EpaWordAddrWidth = 16;
  localparam logic [31:0] SharedLimit = 32'h1 << (EpaWordAddrWidth - 2);
  localparam logic [31:0] HostBit = 32'h1 << (addr_width_p - 1);
  localparam logic [y_cord_width_p-1:0] YBottom = y_cord_width_p'(num_tiles_y_p + 1);

  typedef enum logic [2:0] {ClsInvalid, ClsDram, ClsGlobal, ClsGroup, ClsShared} cls_e;

  // Stage 1 state
  logic                      s1_v_q;
  logic [31:0]               s1_eva_q;
  logic [x_cord_width_p-1:0] s1_tgo_x_q;
  logic [y_cord_width_p-1:0] s1_tgo_y_q;
  logic [2:0]                s1_lg_x_q, s1_lg_y_q;
  logic                      s1_dram_en_q;
  cls_e                      s1_cls_q;

  // Stage 2 (output) state
  logic                         s2_v_q;
  logic [x_cord_width_p-1:0]    s2_x_q;
  logic [y_cord_width_p-1:0]    s2_y_q;
  logic [addr_width_p-1:0]      s2_epa_q;
  logic                         s2_inv_q;
  logic [fault_cnt_width_p-1:0] fault_cnt_q, fault_cnt_d;

  logic s2_ready, s1_ready;
  cls_e cls_in;

  assign s2_ready = ~s2_v_q | yumi_i;
  assign s1_ready = ~s1_v_q | s2_ready;
  assign ready_o  = s1_ready;

  // Class decode, highest priority first
  always_comb begin
    if (eva_i[31])                   cls_in = ClsDram;
    else if (eva_i[30])              cls_in = ClsGlobal;
    else if (eva_i[29])              cls_in = ClsGroup;
    else if (eva_i[28:27] == 2'b01)  cls_in = ClsShared;
    else                             cls_in = ClsInvalid;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v_q       <= 1'b0;
      s1_eva_q     <= '0;
      s1_tgo_x_q   <= '0;
      s1_tgo_y_q   <= '0;
      s1_lg_x_q    <= '0;
      s1_lg_y_q    <= '0;
      s1_dram_en_q <= 1'b0;
      s1_cls_q     <= ClsInvalid;
    end else if (s1_ready) begin
      s1_v_q <= v_i;
      if (v_i) begin
        s1_eva_q     <= 32'(eva_i);
        s1_tgo_x_q   <= tgo_x_i;
        s1_tgo_y_q   <= tgo_y_i;
        s1_lg_x_q    <= tg_lg_dim_x_i;
        s1_lg_y_q    <= tg_lg_dim_y_i;
        s1_dram_en_q <= dram_enable_i;
        s1_cls_q     <= cls_in;
      end
    end
  end

  // NPA formation; all fields are pulled from the word index eva[30:2]
  logic [31:0] word, blk, bank, shr, shr_local, lx, ly, fx, fy;
  logic [x_cord_width_p-1:0] x_n;
  logic [y_cord_width_p-1:0] y_n;
  logic [addr_width_p-1:0]   epa_n;
  logic                      inv_n;

  always_comb begin
    word      = (s1_eva_q >> 2) & 32'h1fff_ffff;
    blk       = word >> Vb;
    bank      = blk & 32'(dram_banks_p - 1);
    lx        = 32'(s1_lg_x_q);
    ly        = 32'(s1_lg_y_q);
    shr       = word & 32'h01ff_ffff;
    shr_local = shr >> (lx + ly);
    fx        = (word >> 16) & 32'h3f;
    fy        = (word >> 22) & 32'h1f;
    x_n       = '0;
    y_n       = '0;
    epa_n     = '0;
    inv_n     = 1'b0;
    unique case (s1_cls_q)
      ClsDram: begin
        if (s1_dram_en_q) begin
          // bank MSB picks the bottom vcache row; lower bank bits are the column
          x_n   = x_cord_width_p'(bank & ((32'h1 << (Nb - 1)) - 32'h1));
          y_n   = (((bank >> (Nb - 1)) & 32'h1) != 32'h0) ? YBottom : '0;
          epa_n = addr_width_p'(((blk >> Nb) << Vb) | (word & ((32'h1 << Vb) - 32'h1)));
        end else if (word[28]) begin
          // host space
          y_n   = y_cord_width_p'(1);
          epa_n = addr_width_p'(HostBit | (word & (HostBit - 32'h1)));
        end else begin
          x_n   = x_cord_width_p'(word >> Vs);
          y_n   = (((word >> (Vs + x_cord_width_p)) & 32'h1) != 32'h0) ? YBottom : '0;
          epa_n = addr_width_p'(word & ((32'h1 << Vs) - 32'h1));
        end
      end
      ClsGlobal: begin
        x_n   = x_cord_width_p'(fx);
        y_n   = y_cord_width_p'((word >> 22) & 32'h3f);
        epa_n = addr_width_p'(word & 32'hffff);
      end
      ClsGroup: begin
        if (((fx >> lx) != 32'h0) || ((fy >> ly) != 32'h0)) begin
          inv_n = 1'b1;
        end else begin
          x_n   = x_cord_width_p'(32'(s1_tgo_x_q) + fx);
          y_n   = y_cord_width_p'(32'(s1_tgo_y_q) + fy);
          epa_n = addr_width_p'(word & 32'hffff);
        end
      end
      ClsShared: begin
        if (shr_local >= SharedLimit) begin
          inv_n = 1'b1;
        end else begin
          x_n   = x_cord_width_p'(32'(s1_tgo_x_q) + (shr & ((32'h1 << lx) - 32'h1)));
          y_n   = y_cord_width_p'(32'(s1_tgo_y_q) + ((shr >> lx) & ((32'h1 << ly) - 32'h1)));
          epa_n = addr_width_p'(shr_local + 32'(dmem_start_p));
        end
      end
      default: inv_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s2_v_q   <= 1'b0;
      s2_x_q   <= '0;
      s2_y_q   <= '0;
      s2_epa_q <= '0;
      s2_inv_q <= 1'b0;
    end else if (s2_ready) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_x_q   <= x_n;
        s2_y_q   <= y_n;
        s2_epa_q <= epa_n;
        s2_inv_q <= inv_n;
      end
    end
  end

  // Clear wins over a same-cycle increment; increment saturates at all-ones
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (clear_fault_i) begin
      fault_cnt_d = '0;
    end else if (s2_v_q && yumi_i && s2_inv_q && !(&fault_cnt_q)) begin
      fault_cnt_d = fault_cnt_q + fault_cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) fault_cnt_q <= '0;
    else            fault_cnt_q <= fault_cnt_d;
  end

  assign v_o         = s2_v_q;
  assign x_cord_o    = s2_x_q;
  assign y_cord_o    = s2_y_q;
  assign epa_o       = s2_epa_q;
  assign invalid_o   = s2_inv_q;
  assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_bsg_manycore_eva_to_npa_pipe.sv
// Directed bench for bsg_manycore_eva_to_npa_pipe: 16x8 array, 8-word vcache blocks,
// 1024-word vcache, 32 DRAM banks, 28-bit EPA, 4-bit coordinates.
module tb_bsg_manycore_eva_to_npa_pipe;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i, ready_o, dram_enable_i, v_o, yumi_i, invalid_o, clear_fault_i;
  logic [31:0] eva_i;
  logic [3:0]  tgo_x_i, tgo_y_i, x_cord_o, y_cord_o;
  logic [2:0]  tg_lg_dim_x_i, tg_lg_dim_y_i;
  logic [27:0] epa_o;
  logic [7:0]  fault_cnt_o;
  logic [36:0] cur;

  assign cur = {invalid_o, x_cord_o, y_cord_o, epa_o};

  bsg_manycore_eva_to_npa_pipe #(
    .data_width_p(32), .addr_width_p(28), .x_cord_width_p(4), .y_cord_width_p(4),
    .num_tiles_x_p(16), .num_tiles_y_p(8), .vcache_block_size_in_words_p(8),
    .vcache_size_p(1024), .dram_banks_p(32), .dmem_start_p('h400), .fault_cnt_width_p(8)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o), .eva_i(eva_i),
    .tgo_x_i(tgo_x_i), .tgo_y_i(tgo_y_i), .tg_lg_dim_x_i(tg_lg_dim_x_i),
    .tg_lg_dim_y_i(tg_lg_dim_y_i), .dram_enable_i(dram_enable_i), .v_o(v_o),
    .yumi_i(yumi_i), .x_cord_o(x_cord_o), .y_cord_o(y_cord_o), .epa_o(epa_o),
    .invalid_o(invalid_o), .fault_cnt_o(fault_cnt_o), .clear_fault_i(clear_fault_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request into an empty pipe; config is scrambled right after acceptance
  task automatic xlate(input logic [31:0] eva, input logic [3:0] tx, input logic [3:0] ty,
                       input logic [2:0] lx, input logic [2:0] ly, input logic den,
                       output logic [36:0] res, output logic ok);
    @(negedge clk_i);
    eva_i = eva; tgo_x_i = tx; tgo_y_i = ty;
    tg_lg_dim_x_i = lx; tg_lg_dim_y_i = ly; dram_enable_i = den; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0; eva_i = ~eva; tgo_x_i = ~tx; tgo_y_i = ~ty;
    tg_lg_dim_x_i = lx ^ 3'd1; tg_lg_dim_y_i = ly ^ 3'd1; dram_enable_i = ~den;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk_i);
      ok = v_o;
    end
    res = '0;
    if (ok) begin
      res = cur;
      yumi_i = 1'b1;
      @(posedge clk_i); #1;
      yumi_i = 1'b0;
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] eva, input logic [3:0] tx,
                         input logic [3:0] ty, input logic [2:0] lx, input logic [2:0] ly,
                         input logic den, input logic [36:0] exp);
    logic [36:0] res;
    logic        ok;
    xlate(eva, tx, ty, lx, ly, den, res, ok);
    check_eq({tag, "_arrived"}, 64'(ok), 64'd1);
    check_eq(tag, 64'(res), 64'(exp));
  endtask

  function automatic logic [31:0] burst_eva(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return 32'h4000_0000 | ((kk & 32'd7) << 24) | ((kk & 32'd15) << 18) | ((kk + 32'd256) << 2);
  endfunction

  function automatic logic [36:0] burst_exp(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {1'b0, kk[3:0], 1'b0, kk[2:0], 28'(kk + 32'd256)};
  endfunction

  logic [36:0] res_v, prev;
  logic        ok_v, prev_stall;
  int          wr, rd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; clear_fault_i = 1'b0; eva_i = '0;
    tgo_x_i = '0; tgo_y_i = '0; tg_lg_dim_x_i = '0; tg_lg_dim_y_i = '0; dram_enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_v_o", 64'(v_o), 64'd0);
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    check_eq("rst_outputs", 64'(cur), 64'd0);
    check_eq("rst_fault", 64'(fault_cnt_o), 64'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check_eq("post_rst_v_o", 64'(v_o), 64'd0);
    check_eq("post_rst_ready", 64'(ready_o), 64'd1);

    // Striped DRAM
    run_vec("dram_s0", 32'h8000_0020, 4'd0, 4'd0, 3'd0, 3'd0, 1'b1, {1'b0, 4'd1, 4'd0, 28'd0});
    run_vec("dram_s1", 32'h8000_0200, 4'd0, 4'd0, 3'd0, 3'd0, 1'b1, {1'b0, 4'd0, 4'd9, 28'd0});
    run_vec("dram_s2", 32'h8000_0404, 4'd0, 4'd0, 3'd0, 3'd0, 1'b1, {1'b0, 4'd0, 4'd0, 28'd9});
    // DRAM disabled: host, then direct vcache
    run_vec("dram_host", 32'hC000_0010, 4'd0, 4'd0, 3'd0, 3'd0, 1'b0,
            {1'b0, 4'd0, 4'd1, 28'h800_0004});
    run_vec("dram_direct", 32'h8001_3010, 4'd0, 4'd0, 3'd0, 3'd0, 1'b0,
            {1'b0, 4'd3, 4'd9, 28'd4});
    run_vec("global", 32'h4314_0040, 4'd0, 4'd0, 3'd0, 3'd0, 1'b1, {1'b0, 4'd5, 4'd3, 28'h10});
    // Shared
    run_vec("shared_22", 32'h0800_0094, 4'd4, 4'd2, 3'd2, 3'd2, 1'b1,
            {1'b0, 4'd5, 4'd3, 28'h402});
    run_vec("shared_11", 32'h0800_0094, 4'd4, 4'd2, 3'd1, 3'd1, 1'b1,
            {1'b0, 4'd5, 4'd2, 28'h409});
    run_vec("shared_edge", 32'h0800_FFFC, 4'd4, 4'd2, 3'd0, 3'd0, 1'b1,
            {1'b0, 4'd4, 4'd2, 28'h43FF});
    run_vec("shared_oob", 32'h0801_0000, 4'd4, 4'd2, 3'd0, 3'd0, 1'b1, {1'b1, 36'd0});
    // Tile group
    run_vec("tg_ok", 32'h2204_0080, 4'd4, 4'd2, 3'd2, 3'd2, 1'b1, {1'b0, 4'd5, 4'd4, 28'h20});
    run_vec("tg_fx_oob", 32'h2010_0000, 4'd4, 4'd2, 3'd2, 3'd2, 1'b1, {1'b1, 36'd0});
    run_vec("no_class", 32'h0000_1000, 4'd4, 4'd2, 3'd2, 3'd2, 1'b1, {1'b1, 36'd0});
    @(negedge clk_i);
    check_eq("fault_3", 64'(fault_cnt_o), 64'd3);

    for (int i = 0; i < 300; i++) xlate(32'h0000_1000, 4'd4, 4'd2, 3'd2, 3'd2, 1'b1, res_v, ok_v);
    @(negedge clk_i);
    check_eq("fault_sat", 64'(fault_cnt_o), 64'd255);

    // Clear in the same cycle as an invalid consume: clear wins
    v_i = 1'b1; eva_i = 32'h0000_1000;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    ok_v = 1'b0;
    for (int i = 0; i < 8 && !ok_v; i++) begin
      @(negedge clk_i);
      ok_v = v_o;
    end
    check_eq("clr_arrived", 64'(ok_v), 64'd1);
    yumi_i = ok_v; clear_fault_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0; clear_fault_i = 1'b0;
    @(negedge clk_i);
    check_eq("fault_clear", 64'(fault_cnt_o), 64'd0);
    xlate(32'h0000_1000, 4'd4, 4'd2, 3'd2, 3'd2, 1'b1, res_v, ok_v);
    @(negedge clk_i);
    check_eq("fault_after_clr", 64'(fault_cnt_o), 64'd1);

    // Burst of 16 with random backpressure
    wr = 0; rd = 0; prev_stall = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 1000 && rd < 16; cyc++) begin
      @(negedge clk_i);
      if (prev_stall) check_eq("stall_hold", 64'(cur), 64'(prev));
      yumi_i = v_o && ($urandom_range(0, 2) != 0);
      if (v_o && yumi_i) begin
        check_eq($sformatf("burst[%0d]", rd), 64'(cur), 64'(burst_exp(rd)));
        rd++;
      end
      prev_stall = v_o && !yumi_i;
      prev = cur;
      v_i = (wr < 16);
      eva_i = burst_eva(wr);
      #1;
      if (v_i && ready_o) wr++;
    end
    @(negedge clk_i);
    v_i = 1'b0; yumi_i = 1'b0;
    check_eq("burst_count", 64'(rd), 64'd16);
    repeat (3) @(negedge clk_i);
    check_eq("burst_no_dup", 64'(v_o), 64'd0);

    // Reset mid-flight
    v_i = 1'b1; eva_i = burst_eva(0);
    repeat (3) @(negedge clk_i);
    check_eq("prefill_v_o", 64'(v_o), 64'd1);
    check_eq("prefill_ready", 64'(ready_o), 64'd0);
    #2;
    reset_n_i = 1'b0; v_i = 1'b0;
    #1;
    check_eq("midrst_v_o", 64'(v_o), 64'd0);
    check_eq("midrst_ready", 64'(ready_o), 64'd1);
    check_eq("midrst_fault", 64'(fault_cnt_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("after_rst_v_o", 64'(v_o), 64'd0);
    check_eq("after_rst_ready", 64'(ready_o), 64'd1);
    run_vec("after_rst_global", burst_eva(5), 4'd0, 4'd0, 3'd0, 3'd0, 1'b1, burst_exp(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
